// File: rtl/partition_write_scheduler.sv
// Round-robin arbiter sharing one partition write port among NUM_PART requesters, with Avalon-MM mask/quota config.
// Capture-to-wr_valid latency 1 cycle; output register stalls on wr_ready=0. Optional PWS_STATS_EN adds per-partition beat counters.
module partition_write_scheduler #(
  parameter int NUM_PART = 5,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int QUOTA_W  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_PART-1:0]        req_valid,
  output logic [NUM_PART-1:0]        req_ready,
  input  logic [NUM_PART*ADDR_W-1:0] req_addr,
  input  logic [NUM_PART*DATA_W-1:0] req_data,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic [2:0]                 wr_part,
  output logic [NUM_PART-1:0]        part_write_enables,
  input  logic [2:0]                 avs_address,
  input  logic                       avs_read,
  output logic [63:0]                avs_readdata,
  input  logic                       avs_write,
  input  logic [63:0]                avs_writedata,
  output logic                       avs_waitrequest
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  localparam logic [2:0] LAST_PART = 3'(NUM_PART - 1);

  state_t               state, state_nxt;
  logic [NUM_PART-1:0]  mask;
  logic [NUM_PART-1:0]  elig;
  logic [QUOTA_W-1:0]   quota;
  logic [QUOTA_W-1:0]   beats_left, beats_left_nxt;
  logic [2:0]           owner;
  logic [2:0]           rr_ptr;
  logic [2:0]           pick_idx;
  logic                 pick_vld;
  logic [2:0]           cap_idx;
  logic                 cap_en;
  logic                 cap_ok;
  logic                 hs;
  logic                 clr;
  logic [31:0]          grant_count;
  logic [63:0]          stats_word;

  assign elig               = req_valid & mask;
  assign hs                 = wr_valid & wr_ready;
  assign cap_ok             = !wr_valid || wr_ready;
  assign clr                = avs_write && (avs_address == 3'd3);
  assign part_write_enables = mask;
  assign avs_waitrequest    = 1'b0;

  // Strobe and upper write-data bits carry no information for this register map.
  logic unused_ok;
  assign unused_ok = &{1'b0, avs_read, avs_writedata};

  // First eligible requester strictly after the last grant, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= NUM_PART; k++) begin
      if (!pick_vld && elig[3'((int'(rr_ptr) + k) % NUM_PART)]) begin
        pick_vld = 1'b1;
        pick_idx = 3'((int'(rr_ptr) + k) % NUM_PART);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      beats_left <= '0;
    end else begin
      state      <= state_nxt;
      beats_left <= beats_left_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    beats_left_nxt = beats_left;
    cap_en         = 1'b0;
    cap_idx        = owner;
    case (state)
      IDLE: begin
        if (pick_vld && cap_ok) begin
          cap_en         = 1'b1;
          cap_idx        = pick_idx;
          // A zero quota still grants one beat.
          beats_left_nxt = (quota == '0) ? '0 : quota - 1'b1;
          if (quota > QUOTA_W'(1)) begin
            state_nxt = OWN;
          end
        end
      end
      OWN: begin
        if (cap_ok) begin
          if (elig[owner]) begin
            cap_en         = 1'b1;
            beats_left_nxt = beats_left - 1'b1;
            if (beats_left == QUOTA_W'(1)) begin
              state_nxt = IDLE;
            end
          end else begin
            // Owner dropped valid or lost its enable: give the port back now.
            state_nxt      = IDLE;
            beats_left_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt      = IDLE;
        beats_left_nxt = '0;
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (cap_en) begin
      req_ready = NUM_PART'(1) << cap_idx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner  <= '0;
      rr_ptr <= LAST_PART;
    end else if (cap_en && state == IDLE) begin
      owner  <= cap_idx;
      rr_ptr <= cap_idx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_part  <= '0;
    end else if (cap_en) begin
      wr_valid <= 1'b1;
      wr_addr  <= req_addr[int'(cap_idx)*ADDR_W +: ADDR_W];
      wr_data  <= req_data[int'(cap_idx)*DATA_W +: DATA_W];
      wr_part  <= cap_idx;
    end else if (hs) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_part  <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask  <= '0;
      quota <= QUOTA_W'(1);
    end else if (avs_write) begin
      if (avs_address == 3'd0) begin
        mask <= avs_writedata[NUM_PART-1:0];
      end
      if (avs_address == 3'd1) begin
        quota <= avs_writedata[QUOTA_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_count <= '0;
    end else if (clr) begin
      grant_count <= '0;
    end else if (hs) begin
      grant_count <= grant_count + 32'd1;
    end
  end

`ifdef PWS_STATS_EN
  logic [11:0]            stat_cnt [NUM_PART];
  logic [NUM_PART*12-1:0] stat_flat;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PART; i++) begin
        stat_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PART; i++) begin
        if (clr) begin
          stat_cnt[i] <= '0;
        end else if (hs && wr_part == 3'(i) && stat_cnt[i] != 12'hFFF) begin
          stat_cnt[i] <= stat_cnt[i] + 12'd1;
        end
      end
    end
  end

  always_comb begin
    stat_flat = '0;
    for (int i = 0; i < NUM_PART; i++) begin
      stat_flat[i*12 +: 12] = stat_cnt[i];
    end
  end

  // Only the counters that fit in the 64-bit read word are visible.
  assign stats_word = 64'(stat_flat);
`else
  assign stats_word = '0;
`endif

  always_comb begin
    avs_readdata = '0;
    case (avs_address)
      3'd0:    avs_readdata = 64'(mask);
      3'd1:    avs_readdata = 64'(quota);
      3'd2:    avs_readdata = {grant_count, 23'd0, wr_valid, (state == OWN), 4'd0, owner};
      3'd4:    avs_readdata = stats_word;
      default: avs_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_partition_write_scheduler.sv
// Randomized bench for partition_write_scheduler against a transaction-level model of the arbiter.
module tb_partition_write_scheduler;
  localparam int NP = 5;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int QW = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_ready;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [2:0]       wr_part;
  logic [NP-1:0]    part_write_enables;
  logic [2:0]       avs_address;
  logic             avs_read;
  logic [63:0]      avs_readdata;
  logic             avs_write;
  logic [63:0]      avs_writedata;
  logic             avs_waitrequest;

  partition_write_scheduler #(.NUM_PART(NP), .ADDR_W(AW), .DATA_W(DW), .QUOTA_W(QW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_part(wr_part),
    .part_write_enables(part_write_enables),
    .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model: who owns the port, how many beats of the burst remain, the pending beat.
  logic [NP-1:0] m_mask;
  int            m_quota;
  int            m_rr;
  int            m_owner;
  bit            m_own;
  int            m_left;
  bit            m_ov;
  logic [AW-1:0] m_oaddr;
  logic [DW-1:0] m_odata;
  int            m_opart;
  logic [31:0]   m_gc;
  int            m_st [NP];
  int            parts_log [$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mask = '0; m_quota = 1; m_rr = NP - 1; m_owner = 0; m_own = 0; m_left = 0;
    m_ov = 0; m_oaddr = '0; m_odata = '0; m_opart = 0; m_gc = '0;
    for (int i = 0; i < NP; i++) m_st[i] = 0;
  endtask

  function automatic logic [63:0] exp_read(logic [2:0] a);
    logic [63:0] r;
    r = '0;
    case (a)
      3'd0: r = 64'(m_mask);
      3'd1: r = 64'(m_quota);
      3'd2: begin
        r[63:32] = m_gc;
        r[8]     = m_ov;
        r[7]     = m_own;
        r[2:0]   = 3'(m_owner);
      end
      3'd4: begin
`ifdef PWS_STATS_EN
        for (int i = 0; i < NP; i++) if (i * 12 + 12 <= 64) r[i*12 +: 12] = 12'(m_st[i]);
`endif
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic rnd_data();
    for (int i = 0; i < NP; i++) begin
      req_addr[i*AW +: AW] = $urandom;
      req_data[i*DW +: DW] = {$urandom, $urandom};
    end
  endtask

  // One clock: called just after a falling edge with inputs applied; checks, then advances the model.
  task automatic cycle();
    logic [NP-1:0] elig;
    logic [NP-1:0] exp_rdy;
    logic [AW-1:0] naddr;
    logic [DW-1:0] ndata;
    bit cap, nown, hs;
    int idx, nleft;
    #1;
    elig  = req_valid & m_mask;
    cap   = 0; idx = m_owner; nleft = m_left; nown = m_own;
    if (!m_ov || wr_ready) begin
      if (!m_own) begin
        for (int k = 1; k <= NP; k++)
          if (!cap && elig[(m_rr + k) % NP]) begin cap = 1; idx = (m_rr + k) % NP; end
        if (cap) begin
          nleft = (m_quota == 0 ? 1 : m_quota) - 1;
          nown  = nleft > 0;
        end
      end else if (elig[m_owner]) begin
        cap = 1; nleft = m_left - 1; nown = nleft > 0;
      end else begin
        nown = 0; nleft = 0;
      end
    end
    exp_rdy = cap ? (NP'(1) << idx) : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("wr_valid", 64'(wr_valid), 64'(m_ov));
    if (m_ov) begin
      chk("wr_addr", 64'(wr_addr), 64'(m_oaddr));
      chk("wr_data", wr_data, m_odata);
      chk("wr_part", 64'(wr_part), 64'(m_opart));
    end
    chk("part_write_enables", 64'(part_write_enables), 64'(m_mask));
    chk("avs_readdata", avs_readdata, exp_read(avs_address));
    chk("avs_waitrequest", 64'(avs_waitrequest), 64'd0);
    hs    = m_ov && wr_ready;
    naddr = req_addr[idx*AW +: AW];
    ndata = req_data[idx*DW +: DW];
    if (hs) parts_log.push_back(m_opart);
    @(posedge clock);
    if (avs_write && avs_address == 3'd3) begin
      m_gc = '0;
      for (int i = 0; i < NP; i++) m_st[i] = 0;
    end else if (hs) begin
      m_gc = m_gc + 32'd1;
      if (m_st[m_opart] < 4095) m_st[m_opart]++;
    end
    if (cap) begin
      m_ov = 1; m_oaddr = naddr; m_odata = ndata; m_opart = idx;
      if (!m_own) begin m_owner = idx; m_rr = idx; end
    end else if (hs) begin
      m_ov = 0;
    end
    m_own  = nown;
    m_left = nleft;
    if (avs_write && avs_address == 3'd0) m_mask  = avs_writedata[NP-1:0];
    if (avs_write && avs_address == 3'd1) m_quota = int'(avs_writedata[QW-1:0]);
    @(negedge clock);
  endtask

  task automatic avs_wr(logic [2:0] a, logic [63:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    cycle();
    avs_write = 1'b0; avs_address = 3'd2;
  endtask

  initial begin
    int exp2 [6];
    int exp3 [7];
    logic [AW-1:0] held;
    exp2 = '{0, 1, 2, 3, 4, 0};
    exp3 = '{1, 1, 1, 3, 3, 3, 1};
    req_valid = '1; wr_ready = 1'b1; avs_address = 3'd2; avs_read = 1'b0;
    avs_write = 1'b0; avs_writedata = '0; req_addr = '0; req_data = '0;
    model_reset();
    rnd_data();
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Out of reset with mask clear: nothing may be granted.
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_enables", 64'(part_write_enables), 64'd0);
    repeat (3) cycle();

    // Quota 1, all requesters: strict rotation starting at 0.
    req_valid = '0;
    avs_wr(3'd0, 64'h1F);
    avs_wr(3'd1, 64'd1);
    req_valid = '1;
    parts_log.delete();
    repeat (6) begin rnd_data(); cycle(); end
    req_valid = '0;
    repeat (2) cycle();
    chk("rot_len", 64'(parts_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) if (i < parts_log.size()) chk("rot_part", 64'(parts_log[i]), 64'(exp2[i]));

    // Quota 3, requesters 1 and 3.
    avs_wr(3'd1, 64'd3);
    req_valid = 5'b01010;
    parts_log.delete();
    repeat (9) begin rnd_data(); cycle(); end
    chk("burst_len", 64'(parts_log.size()), 64'd8);
    for (int i = 0; i < 7; i++) if (i < parts_log.size()) chk("burst_part", 64'(parts_log[i]), 64'(exp3[i]));
    #1;
    chk("burst_owner", 64'(avs_readdata[2:0]), 64'd1);
    chk("burst_state", 64'(avs_readdata[7]), 64'd0);
    chk("burst_pending", 64'(avs_readdata[8]), 64'd1);

    // Backpressure: pending beat frozen, no new captures.
    wr_ready = 1'b0;
    held = m_oaddr;
    repeat (4) begin
      rnd_data();
      #1;
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_wr_addr", 64'(wr_addr), 64'(held));
      cycle();
    end
    wr_ready = 1'b1;
    repeat (4) begin rnd_data(); cycle(); end
    req_valid = '0;
    repeat (4) cycle();

    // Mask cleared while partition 2 owns a 3-beat burst.
    req_valid = 5'b00100;
    parts_log.delete();
    rnd_data(); cycle();
    rnd_data(); avs_wr(3'd0, 64'd0);
    repeat (4) begin rnd_data(); cycle(); end
    chk("mask_len", 64'(parts_log.size()), 64'd2);
    for (int i = 0; i < 2; i++) if (i < parts_log.size()) chk("mask_part", 64'(parts_log[i]), 64'd2);
    #1;
    chk("mask_state", 64'(avs_readdata[7]), 64'd0);
    chk("mask_pending", 64'(avs_readdata[8]), 64'd0);

    // Random traffic with random config writes.
    for (int n = 0; n < 3000; n++) begin
      rnd_data();
      req_valid   = NP'($urandom);
      wr_ready    = ($urandom_range(0, 3) != 0);
      avs_address = 3'($urandom_range(0, 7));
      avs_write   = ($urandom_range(0, 19) == 0);
      avs_writedata = {$urandom, $urandom};
      cycle();
      avs_write = 1'b0;
    end
    avs_address = 3'd2;
    req_valid = '0; wr_ready = 1'b1;
    repeat (4) cycle();

    // Long single-partition run: counters saturate, grant_count keeps counting.
    avs_wr(3'd3, 64'd0);
    avs_wr(3'd1, 64'd1);
    avs_wr(3'd0, 64'd1);
    req_valid = '1;
    repeat (4100) begin rnd_data(); cycle(); end
    req_valid = '0;
    repeat (2) cycle();
    #1;
    chk("long_grants", 64'(avs_readdata[63:32]), 64'd4100);
    avs_address = 3'd4;
    #1;
`ifdef PWS_STATS_EN
    chk("stat_saturate", avs_readdata, 64'd4095);
`else
    chk("stat_absent", avs_readdata, 64'd0);
`endif
    avs_address = 3'd2;

    // Ten grants, then a clear.
    avs_wr(3'd3, 64'd0);
    avs_wr(3'd0, 64'h1F);
    req_valid = '1;
    repeat (10) begin rnd_data(); cycle(); end
    req_valid = '0;
    repeat (2) cycle();
    #1;
    chk("ten_grants", 64'(avs_readdata[63:32]), 64'd10);
    avs_wr(3'd3, 64'hDEAD);
    #1;
    chk("clr_grants", 64'(avs_readdata[63:32]), 64'd0);
    avs_address = 3'd4;
    #1;
    chk("clr_stats", avs_readdata, 64'd0);
    avs_address = 3'd3;
    #1;
    chk("addr3_read", avs_readdata, 64'd0);
    avs_address = 3'd2;
    cycle();

    // Reset in the middle of a burst drops everything.
    avs_wr(3'd1, 64'd3);
    req_valid = 5'b00100;
    rnd_data(); cycle();
    rnd_data(); cycle();
    reset = 1'b1;
    #2;
    chk("rst_mid_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_mid_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mid_enables", 64'(part_write_enables), 64'd0);
    chk("rst_mid_status", avs_readdata, 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    req_valid = '1;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
